// File: rtl/tri_err_rpt_latch.sv
// Error-report latch: masks and injects raw unit errors, then reports them either
// registered or sticky. Also captures the first error vector and counts error events.
module tri_err_rpt_latch #(
    parameter int WIDTH      = 1,
    parameter int STICKY     = 1,
    parameter int CNT_WIDTH  = 4,
    parameter int MASK_RESET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inout  wire                  vd,
    inout  wire                  gd,
    input  logic [0:WIDTH-1]     err_in,
    input  logic [0:WIDTH-1]     err_mask,
    input  logic [0:WIDTH-1]     err_inj,
    input  logic [0:WIDTH-1]     err_clr,
    input  logic                 first_clr,
    input  logic                 cnt_clr,
    output logic [0:WIDTH-1]     err_out,
    output logic                 err_any,
    output logic                 first_err_valid,
    output logic [0:WIDTH-1]     first_err_vec,
    output logic [0:CNT_WIDTH-1] err_cnt
);

    typedef enum logic {IDLE, CAPT} state_t;

    state_t               state_reg, state_next;
    logic [0:WIDTH-1]     eff;
    logic [0:WIDTH-1]     rise;
    logic [0:WIDTH-1]     eff_q_reg;
    logic [0:WIDTH-1]     err_out_reg;
    logic [0:WIDTH-1]     first_vec_reg, first_vec_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic                 event_hit;

    // Power rails are carried for the macro boundary only.
    wire analysis_not_referenced;
    assign analysis_not_referenced = vd | gd;
    wire unused_sink = analysis_not_referenced | (MASK_RESET != 0) | (^err_clr);

    assign eff       = (err_in | err_inj) & ~err_mask;
    assign rise      = eff & ~eff_q_reg;
    assign event_hit = |rise;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (STICKY != 0) begin : g_sticky
                // A new error beats a clear arriving in the same cycle.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        err_out_reg[gi] <= 1'b0;
                    else
                        err_out_reg[gi] <= eff[gi] | (err_out_reg[gi] & ~err_clr[gi]);
                end
            end else begin : g_direct
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        err_out_reg[gi] <= 1'b0;
                    else
                        err_out_reg[gi] <= eff[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_q_reg     <= '0;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
            first_vec_reg <= '0;
        end else begin
            eff_q_reg     <= eff;
            cnt_reg       <= cnt_next;
            state_reg     <= state_next;
            first_vec_reg <= first_vec_next;
        end
    end

    // Saturating event counter; a clear coinciding with an event restarts at one.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr)
            cnt_next = event_hit ? CNT_WIDTH'(1) : '0;
        else if (event_hit && (cnt_reg != '1))
            cnt_next = cnt_reg + CNT_WIDTH'(1);
    end

    always_comb begin
        state_next     = state_reg;
        first_vec_next = first_vec_reg;
        case (state_reg)
            IDLE: begin
                if (|eff) begin
                    first_vec_next = eff;
                    state_next     = CAPT;
                end
            end
            CAPT: begin
                // Clearing while an error is still present recaptures it at once.
                if (first_clr) begin
                    first_vec_next = eff;
                    state_next     = (|eff) ? CAPT : IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                first_vec_next = '0;
            end
        endcase
    end

    assign err_out         = err_out_reg;
    assign err_any         = |err_out_reg;
    assign first_err_valid = (state_reg == CAPT);
    assign first_err_vec   = first_vec_reg;
    assign err_cnt         = cnt_reg;

endmodule

// File: tb/tb_tri_err_rpt_latch.sv
// Scoreboard bench for tri_err_rpt_latch: sticky and direct instances driven in parallel,
// expectations from a spec-level model, checked by an independent monitor.
module tb_tri_err_rpt_latch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    wire        vd = 1'b1;
    wire        gd = 1'b0;
    logic [0:3] err_in = '0, err_mask = '0, err_inj = '0, err_clr = '0;
    logic       first_clr = 1'b0, cnt_clr = 1'b0;

    logic [0:3] s_out, d_out, s_first, d_first;
    logic       s_any, d_any, s_valid, d_valid;
    logic [0:1] s_cnt, d_cnt;

    always #5 clk = ~clk;

    tri_err_rpt_latch #(.WIDTH(4), .STICKY(1), .CNT_WIDTH(2), .MASK_RESET(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .vd(vd), .gd(gd),
        .err_in(err_in), .err_mask(err_mask), .err_inj(err_inj), .err_clr(err_clr),
        .first_clr(first_clr), .cnt_clr(cnt_clr),
        .err_out(s_out), .err_any(s_any), .first_err_valid(s_valid),
        .first_err_vec(s_first), .err_cnt(s_cnt)
    );

    tri_err_rpt_latch #(.WIDTH(4), .STICKY(0), .CNT_WIDTH(2), .MASK_RESET(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .vd(vd), .gd(gd),
        .err_in(err_in), .err_mask(err_mask), .err_inj(err_inj), .err_clr(err_clr),
        .first_clr(first_clr), .cnt_clr(cnt_clr),
        .err_out(d_out), .err_any(d_any), .first_err_valid(d_valid),
        .first_err_vec(d_first), .err_cnt(d_cnt)
    );

    typedef struct packed {
        logic [0:3] out_s;
        logic       any_s;
        logic [0:3] out_d;
        logic       any_d;
        logic       valid;
        logic [0:3] first;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;
    bit   mon_en = 1'b0;

    // Reference state, in the terms the behaviour is described in.
    logic [0:3] m_out_s = '0, m_out_d = '0, m_prev = '0, m_first = '0;
    bit         m_valid = 1'b0;
    int         m_cnt = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step(input logic [0:3] in, input logic [0:3] clr = 4'b0,
                        input logic fc = 1'b0, input logic cc = 1'b0,
                        input logic [0:3] mask = 4'b0, input logic [0:3] inj = 4'b0,
                        input logic rn = 1'b1);
        logic [0:3] eff;
        bit         ev;
        exp_t       e;
        @(negedge clk);
        err_in = in; err_clr = clr; first_clr = fc; cnt_clr = cc;
        err_mask = mask; err_inj = inj; rst_n = rn;
        if (!rn) begin
            m_out_s = '0; m_out_d = '0; m_prev = '0; m_first = '0;
            m_valid = 1'b0; m_cnt = 0;
            #1;
            chk("async_rst_err_out", int'(s_out), 0);
            chk("async_rst_err_any", int'(s_any), 0);
            chk("async_rst_valid", int'(s_valid), 0);
            chk("async_rst_first", int'(s_first), 0);
            chk("async_rst_cnt", int'(s_cnt), 0);
            chk("async_rst_direct_out", int'(d_out), 0);
        end else begin
            eff = (in | inj) & ~mask;
            ev = 1'b0;
            for (int b = 0; b < 4; b++)
                if (eff[b] && !m_prev[b]) ev = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (eff[b]) m_out_s[b] = 1'b1;
                else if (clr[b]) m_out_s[b] = 1'b0;
            end
            m_out_d = eff;
            if (cc) m_cnt = ev ? 1 : 0;
            else if (ev) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
            if (!m_valid) begin
                if (eff != 0) begin m_valid = 1'b1; m_first = eff; end
            end else if (fc) begin
                m_first = eff;
                m_valid = (eff != 0);
            end
            m_prev = eff;
        end
        e.out_s = m_out_s; e.any_s = (m_out_s != 0);
        e.out_d = m_out_d; e.any_d = (m_out_d != 0);
        e.valid = m_valid; e.first = m_first; e.cnt = 2'(m_cnt);
        exp_q.push_back(e);
        mon_en = 1'b1;
    endtask

    // Monitor: every clock the DUT presents a new response; compare against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d: err_out=%b/%b any=%b/%b valid=%b first=%b cnt=%0d", txn,
                         s_out, d_out, s_any, d_any, s_valid, s_first, s_cnt);
                chk("err_out", int'(s_out), int'(e.out_s));
                chk("err_any", int'(s_any), int'(e.any_s));
                chk("first_err_valid", int'(s_valid), int'(e.valid));
                chk("first_err_vec", int'(s_first), int'(e.first));
                chk("err_cnt", int'(s_cnt), int'(e.cnt));
                chk("direct_err_out", int'(d_out), int'(e.out_d));
                chk("direct_err_any", int'(d_any), int'(e.any_d));
                chk("direct_first_vec", int'(d_first), int'(e.first));
                chk("direct_err_cnt", int'(d_cnt), int'(e.cnt));
            end
        end
    end

    initial begin
        // Reset, sticky report and clear
        step(4'b0000, 4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        step(4'b0000, 4'b0, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        step(4'b0100);
        step(4'b0000);
        step(4'b0000);
        step(4'b0000, 4'b0100);
        step(4'b0000);
        // Mask and inject, then set/clear collision
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        step(4'b0000, 4'b0000, 1'b0, 1'b0, 4'b1000, 4'b1001);
        step(4'b0000);
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        step(4'b0010, 4'b0010);
        step(4'b0000);
        // Counter saturation and clear-with-event
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        for (int p = 0; p < 5; p++) begin
            step(4'b1000);
            step(4'b0000);
        end
        step(4'b1000, 4'b0000, 1'b0, 1'b1);
        step(4'b0000);
        // Multi-bit event and first capture
        step(4'b0000, 4'b1111, 1'b1, 1'b1);
        step(4'b0110);
        step(4'b0000);
        step(4'b1000);
        step(4'b0000);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b1000);
        step(4'b1000, 4'b0000, 1'b1);
        step(4'b0000);
        // Async reset mid-operation, error held through release
        step(4'b1111);
        step(4'b0000);
        step(4'b0001);
        step(4'b0000);
        step(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        step(4'b0001, 4'b0000, 1'b0, 1'b0, 4'b0, 4'b0, 1'b0);
        step(4'b0001);
        step(4'b0000);
        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            step(4'($urandom),
                 ($urandom % 3 == 0) ? 4'($urandom) : 4'b0,
                 ($urandom % 6 == 0),
                 ($urandom % 8 == 0),
                 ($urandom % 4 == 0) ? 4'($urandom) : 4'b0,
                 ($urandom % 5 == 0) ? 4'($urandom) : 4'b0,
                 ($urandom % 50 != 0));
        end
        @(posedge clk);
        #5;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
